// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes and a sticky trap.
// Optional: define MCU_PERF_CNT_EN to add cycle_cnt/instret_cnt performance counters.
module multicycle_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 200,
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned ALUCTRL_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 branch_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 alu_src,
    output logic                 alu_a_pc,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 trap,
    output logic [1:0]           trap_cause
`ifdef MCU_PERF_CNT_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instret_cnt
`endif
);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(9);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BR,
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_ILL
    } cls_e;

    state_e               state_q, state_d;
    cls_e                 cls_q, cls_d, dec_cls;
    logic                 run_q;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 trap_q, trap_d;
    logic [1:0]           cause_q, cause_d;
    logic [ALUCTRL_W-1:0] arith_op;

    // Instruction class from the IR opcode field
    always_comb begin
        dec_cls = CLS_ILL;
        if (opcode[1:0] == 2'b11) begin
            case (opcode[6:2])
                5'b01100: dec_cls = CLS_R;
                5'b00100: dec_cls = CLS_I;
                5'b00000: dec_cls = CLS_LOAD;
                5'b01000: dec_cls = CLS_STORE;
                5'b11000: dec_cls = CLS_BR;
                5'b01101: dec_cls = CLS_LUI;
                5'b00101: dec_cls = CLS_AUIPC;
                5'b11011: dec_cls = CLS_JAL;
                5'b11001: dec_cls = CLS_JALR;
                default:  dec_cls = CLS_ILL;
            endcase
        end
    end

    // ALU op for R/I; funct7b5 selects SUB only for register ADD, and SRA for both shifts
    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000:  arith_op = (cls_q == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        tmo_d     = tmo_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_src   = 1'b0;
        alu_a_pc  = 1'b0;
        alu_ctrl  = ALU_ADD;

        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ST_TRAP;
                        trap_d  = 1'b1;
                        cause_d = 2'b10;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            ST_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == CLS_ILL) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_R: begin
                        alu_ctrl = arith_op;
                        state_d  = ST_WB;
                    end
                    CLS_I: begin
                        alu_ctrl = arith_op;
                        alu_src  = 1'b1;
                        state_d  = ST_WB;
                    end
                    CLS_LUI: state_d = ST_WB;
                    CLS_AUIPC: begin
                        alu_a_pc = 1'b1;
                        alu_src  = 1'b1;
                        state_d  = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src = 1'b1;
                        state_d = ST_MEM;
                    end
                    CLS_BR: begin
                        alu_ctrl = ALU_SUB;
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'b01 : 2'b00;
                        state_d  = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_src    = (cls_q == CLS_JAL) ? 2'b01 : 2'b10;
                        state_d   = ST_FETCH;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (cls_q == CLS_LOAD);
                mem_write = (cls_q == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_q == CLS_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = (cls_q == CLS_LOAD) ? 2'b01 :
                            (cls_q == CLS_LUI)  ? 2'b11 : 2'b00;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
            default: ;
        endcase

        // Each new memory wait starts a fresh timeout window
        if (state_d != state_q && (state_d == ST_FETCH || state_d == ST_MEM)) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_ILL;
            run_q   <= 1'b0;
            tmo_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            run_q   <= 1'b1;
            tmo_q   <= tmo_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;

`ifdef MCU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (run_q && !trap_q) cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_write)         instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: instruction-level reference model plus directed pins.
module tb_multicycle_control_unit;

    localparam int unsigned MEM_TIMEOUT = 200;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                   K_LUI = 5, K_AUIPC = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       alu_src;
        logic       alu_a_pc;
        logic [3:0] alu_ctrl;
        logic       trap;
        logic [1:0] trap_cause;
    } outv_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic funct7b5, branch_taken, imem_ready, dmem_ready;
    logic imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, reg_write;
    logic alu_src, alu_a_pc, trap;
    logic [1:0] pc_src, wb_sel, trap_cause;
    logic [3:0] alu_ctrl;
`ifdef MCU_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .wb_sel(wb_sel), .alu_src(alu_src), .alu_a_pc(alu_a_pc), .alu_ctrl(alu_ctrl),
        .trap(trap), .trap_cause(trap_cause)
`ifdef MCU_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    outv_t act_v, exp_v;
    assign act_v = {imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
                    reg_write, wb_sel, alu_src, alu_a_pc, alu_ctrl, trap, trap_cause};

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit trapped = 1'b0;
    logic [1:0] tcause = 2'b00;
    outv_t hist[$];

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, a, e);
        end
    endtask

    // Per-cycle comparison against the model's expected output vector
    always @(negedge clk) begin
        if (chk_en) begin
            hist.push_back(act_v);
            check("outputs", 32'(act_v), 32'(exp_v));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        branch_taken = 1'($urandom);
        imem_ready   = 1'($urandom);
        dmem_ready   = 1'($urandom);
    endtask

    function automatic int class_of(input logic [6:0] op);
        if (op[1:0] != 2'b11) return K_ILL;
        case (op[6:2])
            5'b01100: return K_R;
            5'b00100: return K_I;
            5'b00000: return K_LD;
            5'b01000: return K_ST;
            5'b11000: return K_BR;
            5'b01101: return K_LUI;
            5'b00101: return K_AUIPC;
            5'b11011: return K_JAL;
            5'b11001: return K_JALR;
            default:  return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input bit is_r);
        case (f3)
            3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // One instruction: drives inputs and sets the expected outputs cycle by cycle
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int iw, input int dw, input bit tk, input int abort_mem);
        int k;
        k = class_of(op);
        for (int i = 0; i < iw && i < int'(MEM_TIMEOUT); i++) begin
            noise(); imem_ready = 1'b0;
            exp_v = '0; exp_v.imem_req = 1'b1;
            tick();
        end
        if (iw >= int'(MEM_TIMEOUT)) begin
            trapped = 1'b1; tcause = 2'b10;
            return;
        end
        noise(); imem_ready = 1'b1;
        exp_v = '0; exp_v.imem_req = 1'b1; exp_v.ir_write = 1'b1;
        tick();
        opcode = op; funct3 = f3; funct7b5 = f7;
        noise();
        exp_v = '0;
        tick();
        if (k == K_ILL) begin
            trapped = 1'b1; tcause = 2'b01;
            return;
        end
        noise();
        exp_v = '0;
        case (k)
            K_R:     exp_v.alu_ctrl = alu_of(f3, f7, 1'b1);
            K_I:     begin exp_v.alu_ctrl = alu_of(f3, f7, 1'b0); exp_v.alu_src = 1'b1; end
            K_AUIPC: begin exp_v.alu_a_pc = 1'b1; exp_v.alu_src = 1'b1; end
            K_LD, K_ST: exp_v.alu_src = 1'b1;
            K_BR: begin
                branch_taken = tk;
                exp_v.alu_ctrl = 4'd1; exp_v.pc_write = 1'b1;
                exp_v.pc_src = tk ? 2'b01 : 2'b00;
            end
            K_JAL, K_JALR: begin
                exp_v.reg_write = 1'b1; exp_v.wb_sel = 2'b10; exp_v.pc_write = 1'b1;
                exp_v.pc_src = (k == K_JAL) ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
        tick();
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < dw && i < int'(MEM_TIMEOUT); i++) begin
                if (i == abort_mem) return;
                noise(); dmem_ready = 1'b0;
                exp_v = '0; exp_v.dmem_req = 1'b1;
                exp_v.mem_read = (k == K_LD); exp_v.mem_write = (k == K_ST);
                tick();
            end
            if (dw >= int'(MEM_TIMEOUT)) begin
                trapped = 1'b1; tcause = 2'b11;
                return;
            end
            noise(); dmem_ready = 1'b1;
            exp_v = '0; exp_v.dmem_req = 1'b1;
            exp_v.mem_read = (k == K_LD); exp_v.mem_write = (k == K_ST);
            exp_v.pc_write = (k == K_ST);
            tick();
        end
        if (k == K_R || k == K_I || k == K_LUI || k == K_AUIPC || k == K_LD) begin
            noise();
            exp_v = '0; exp_v.reg_write = 1'b1; exp_v.pc_write = 1'b1;
            exp_v.wb_sel = (k == K_LD) ? 2'b01 : (k == K_LUI) ? 2'b11 : 2'b00;
            tick();
        end
    endtask

    task automatic hold_trap(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            exp_v = '0; exp_v.trap = 1'b1; exp_v.trap_cause = tcause;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_v = '0;
        #1;
        check("reset_drop", {27'd0, imem_req, dmem_req, pc_write, reg_write, trap},
              32'd0);
        tick();
        tick();
        noise();
        rst_n = 1'b1;
        tick();
        trapped = 1'b0; tcause = 2'b00;
    endtask

    function automatic int first_idx(input int sel);
        foreach (hist[i]) begin
            if ((sel == 0 && hist[i].pc_write) || (sel == 1 && hist[i].reg_write))
                return i;
        end
        return -1;
    endfunction

    function automatic int count_of(input int sel);
        int n = 0;
        foreach (hist[i]) begin
            if ((sel == 0 && hist[i].imem_req) || (sel == 1 && hist[i].dmem_req) ||
                (sel == 2 && hist[i].mem_read) || (sel == 3 && hist[i].ir_write))
                n++;
        end
        return n;
    endfunction

    task automatic split_word(input logic [31:0] w, output logic [6:0] op,
                              output logic [2:0] f3, output logic f7);
        op = w[6:0]; f3 = w[14:12]; f7 = w[30];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic f7;
        int idx;
        logic [6:0] legal_ops [9];
        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

        rst_n = 1'b1; opcode = 7'h13; funct3 = 3'd0; funct7b5 = 1'b0;
        branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_v = '0;
        #1;
        chk_en = 1'b1;
        do_reset();

        // ADD x3,x1,x2 with zero-wait memory
        split_word(32'h002081B3, op, f3, f7);
        hist.delete();
        run_instr(op, f3, f7, 0, 0, 1'b0, -1);
        check("add_imem_req_c1", 32'(hist[0].imem_req), 32'd1);
        check("add_alu_exec", 32'(hist[2].alu_ctrl), 32'd0);
        idx = first_idx(0);
        check("add_pcw_cycle", 32'(idx), 32'd3);
        check("add_regw_cycle", 32'(first_idx(1)), 32'd3);

        // LW with dmem_ready three cycles late
        split_word(32'h0000A183, op, f3, f7);
        hist.delete();
        run_instr(op, f3, f7, 0, 3, 1'b0, -1);
        check("lw_dmem_req_cycles", 32'(count_of(1)), 32'd4);
        check("lw_mem_read_cycles", 32'(count_of(2)), 32'd4);
        idx = first_idx(1);
        check("lw_regw_cycle", 32'(idx), 32'd7);
        if (idx >= 0) check("lw_wb_sel", 32'(hist[idx].wb_sel), 32'd1);

        // BEQ taken and not taken
        split_word(32'h00208463, op, f3, f7);
        for (int t = 1; t >= 0; t--) begin
            hist.delete();
            run_instr(op, f3, f7, 0, 0, t[0], -1);
            idx = first_idx(0);
            check("beq_pcw_cycle", 32'(idx), 32'd2);
            if (idx >= 0) check("beq_pc_src", 32'(hist[idx].pc_src), 32'(t));
            check("beq_no_regw", 32'(first_idx(1)), 32'hFFFF_FFFF);
        end

        // Illegal opcode traps and stays trapped
        run_instr(7'h7F, 3'd0, 1'b0, 0, 0, 1'b0, -1);
        hold_trap(6);
        check("illegal_state", 32'(act_v), 32'h5);
        do_reset();
        check("trap_cleared", 32'(trap), 32'd0);

        // imem timeout: ready never arrives
        hist.delete();
        run_instr(7'h33, 3'd0, 1'b0, MEM_TIMEOUT, 0, 1'b0, -1);
        hold_trap(3);
        check("imem_tmo_req_cycles", 32'(count_of(0)), 32'(MEM_TIMEOUT));
        check("imem_tmo_state", 32'(act_v), 32'h6);
        do_reset();

        // Ready on the last allowed cycle wins
        hist.delete();
        run_instr(7'h33, 3'd0, 1'b0, MEM_TIMEOUT - 1, 0, 1'b0, -1);
        check("imem_last_req_cycles", 32'(count_of(0)), 32'(MEM_TIMEOUT));
        check("imem_last_no_trap", 32'(trap), 32'd0);

        // dmem timeout on a load, then a store whose ready lands on the last cycle
        run_instr(7'h03, 3'd2, 1'b0, 0, MEM_TIMEOUT, 1'b0, -1);
        hold_trap(3);
        check("dmem_tmo_cause", 32'(trap_cause), 32'd3);
        do_reset();
        run_instr(7'h23, 3'd2, 1'b0, 0, MEM_TIMEOUT - 1, 1'b0, -1);
        check("dmem_last_no_trap", 32'(trap), 32'd0);

        // Reset in the middle of a data access drops the request at once
        run_instr(7'h03, 3'd2, 1'b0, 0, 10, 1'b0, 2);
        check("pre_abort_dmem_req", 32'(dmem_req), 32'd1);
        do_reset();

`ifdef MCU_PERF_CNT_EN
        for (int n = 0; n < 10; n++) run_instr(7'h33, 3'd0, 1'b0, 0, 0, 1'b0, -1);
        check("perf_instret", instret_cnt, 32'd10);
        check("perf_cycle", cycle_cnt, 32'd40);
        do_reset();
`endif

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            int iw, dw;
            iw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 1));
            dw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 1));
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                do op = 7'($urandom); while (class_of(op) != K_ILL);
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            run_instr(op, f3, f7, iw, dw, 1'($urandom), -1);
            if (trapped) begin
                hold_trap(int'($urandom_range(1, 4)));
                do_reset();
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
